// File: rtl/pwm_mode_gen_if.sv
// Board-facing signal bundle of pwm_mode_gen: raw keys and duty words in,
// PWM pins, mode LEDs and period tick out.
interface pwm_mode_gen_if #(
    parameter int unsigned N_CH   = 2,
    parameter int unsigned DUTY_W = 8
);
    logic                     key0;
    logic                     key1;
    logic [N_CH*DUTY_W-1:0]   duty;
    logic [N_CH-1:0]          pwm;
    logic                     led0;
    logic                     led1;
    logic                     period_tick;

    modport master (
        output key0, key1, duty,
        input  pwm, led0, led1, period_tick
    );

    modport slave (
        input  key0, key1, duty,
        output pwm, led0, led1, period_tick
    );
endinterface

// File: rtl/pwm_mode_gen.sv
// Multi-channel PWM generator with debounced key selection between two frame
// rates; mode and duty updates are applied only at the period wrap.
module pwm_mode_gen #(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned FREQ_A       = 50,
    parameter int unsigned FREQ_B       = 60,
    parameter int unsigned N_CH         = 2,
    parameter int unsigned DUTY_W       = 8,
    parameter int unsigned CNT_W        = 20,
    parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    pwm_mode_gen_if.slave   bus
);
    localparam int unsigned PER_A = CLK_HZ / FREQ_A;
    localparam int unsigned PER_B = CLK_HZ / FREQ_B;
    localparam int unsigned PW    = CNT_W + DUTY_W;
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYC + 1);

    typedef enum logic {
        MODE_A = 1'b0,
        MODE_B = 1'b1
    } mode_e;

    logic [1:0]       key_raw;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       deb;
    logic [1:0]       deb_d;
    logic [DB_W-1:0]  db_cnt [2];
    logic [1:0]       press;

    mode_e            active, active_nx;
    mode_e            pending, pending_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] per_cur, per_nx;
    logic             wrap;
    logic             tick_nx;
    logic [CNT_W-1:0] cmp    [N_CH];
    logic [CNT_W-1:0] cmp_nx [N_CH];
    logic [PW-1:0]    prod;

    logic [N_CH-1:0]  pwm_q;
    logic             led0_q;
    logic             led1_q;
    logic             tick_q;

    assign key_raw = {bus.key1, bus.key0};
    assign press   = deb_d & ~deb;

    // Synchronise and debounce both keys; level accepted after DEBOUNCE_CYC stable cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
            deb   <= 2'b11;
            deb_d <= 2'b11;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            deb_d <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= MODE_A;
            pending <= MODE_A;
            cnt     <= '0;
            for (int i = 0; i < N_CH; i++) cmp[i] <= '0;
        end else begin
            active  <= active_nx;
            pending <= pending_nx;
            cnt     <= cnt_nx;
            for (int i = 0; i < N_CH; i++) cmp[i] <= cmp_nx[i];
        end
    end

    // Mode request, period counter and compare reload at the wrap
    always_comb begin
        pending_nx = pending;
        active_nx  = active;
        prod       = '0;
        for (int i = 0; i < N_CH; i++) cmp_nx[i] = cmp[i];

        per_cur = (active == MODE_B) ? CNT_W'(PER_B) : CNT_W'(PER_A);
        wrap    = (cnt == per_cur - CNT_W'(1));

        if (press == 2'b01)      pending_nx = MODE_A;
        else if (press == 2'b10) pending_nx = MODE_B;

        if (wrap) active_nx = pending;

        per_nx = (active_nx == MODE_B) ? CNT_W'(PER_B) : CNT_W'(PER_A);
        cnt_nx = wrap ? '0 : cnt + CNT_W'(1);

        for (int i = 0; i < N_CH; i++) begin
            prod = PW'(per_nx) * PW'(bus.duty[i*DUTY_W +: DUTY_W]);
            if (wrap) cmp_nx[i] = CNT_W'(prod >> DUTY_W);
        end

        // Tick registers high exactly while cnt sits at its last value
        tick_nx = (cnt_nx == per_nx - CNT_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q  <= '0;
            led0_q <= 1'b1;
            led1_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) pwm_q[i] <= (cnt < cmp[i]);
            led0_q <= (active_nx == MODE_A);
            led1_q <= (active_nx == MODE_B);
            tick_q <= tick_nx;
        end
    end

    assign bus.pwm         = pwm_q;
    assign bus.led0        = led0_q;
    assign bus.led1        = led1_q;
    assign bus.period_tick = tick_q;
endmodule

// File: tb/tb_pwm_mode_gen.sv
// Scoreboard bench for pwm_mode_gen: per-period expected waveforms are queued
// as stimulus is driven and compared against the outputs every cycle.
module tb_pwm_mode_gen;
    localparam int unsigned PER_A = 20;
    localparam int unsigned PER_B = 16;
    localparam int unsigned DW    = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pwm_mode_gen_if #(.N_CH(2), .DUTY_W(DW)) bus ();

    pwm_mode_gen #(
        .CLK_HZ       (1000),
        .FREQ_A       (50),
        .FREQ_B       (60),
        .N_CH         (2),
        .DUTY_W       (DW),
        .CNT_W        (20),
        .DEBOUNCE_CYC (4)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    bit         mon_en   = 1'b0;
    logic [4:0] sb_q [$];
    logic [4:0] mon_exp;

    // Reference state: mode of the current period and its compare values
    bit         mode_b = 1'b0;
    int         c0     = 0;
    int         c1     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Compare {led1, led0, period_tick, pwm[1], pwm[0]} against the queue head
    always @(negedge clk) begin
        if (mon_en) begin
            chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                mon_exp = sb_q.pop_front();
                chk($sformatf("cyc%0d", cyc),
                    32'({bus.led1, bus.led0, bus.period_tick, bus.pwm}), 32'(mon_exp));
            end
            cyc++;
        end
    end

    task automatic run_period(input bit next_b, input int ncyc,
                              input int k0s, input int k0l,
                              input int k1s, input int k1l,
                              input int dk, input logic [7:0] dval);
        int per;
        int pn;
        logic [4:0] e;
        per = mode_b ? PER_B : PER_A;
        for (int k = 0; k < ncyc; k++) begin
            bus.key0 = !(k >= k0s && k < k0s + k0l);
            bus.key1 = !(k >= k1s && k < k1s + k1l);
            if (k == dk) bus.duty = dval;
            e = {mode_b, !mode_b, (k == per - 1), (k >= 1 && k <= c1), (k >= 1 && k <= c0)};
            sb_q.push_back(e);
            @(posedge clk);
            #1;
        end
        if (ncyc == per) begin
            pn     = next_b ? PER_B : PER_A;
            c0     = (pn * int'(bus.duty[3:0])) >> DW;
            c1     = (pn * int'(bus.duty[7:4])) >> DW;
            mode_b = next_b;
        end
    endtask

    initial begin
        bus.key0 = 1'b1;
        bus.key1 = 1'b1;
        bus.duty = 8'h48;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pwm",  32'(bus.pwm), 32'd0);
        chk("rst_led0", 32'(bus.led0), 32'd1);
        chk("rst_led1", 32'(bus.led1), 32'd0);
        chk("rst_tick", 32'(bus.period_tick), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        run_period(1'b0, PER_A, 0, 0, 0, 0, -1, 8'h00);   // first period, pwm low
        run_period(1'b0, PER_A, 0, 0, 0, 0, -1, 8'h00);   // ch0 10, ch1 5
        run_period(1'b1, PER_A, 0, 0, 2, 10, -1, 8'h00);  // key1 press -> mode B
        run_period(1'b1, PER_B, 0, 0, 0, 0, -1, 8'h00);   // ch0 8, ch1 4
        run_period(1'b1, PER_B, 2, 3, 0, 0, -1, 8'h00);   // key0 glitch ignored
        run_period(1'b1, PER_B, 2, 8, 2, 8, -1, 8'h00);   // simultaneous presses
        run_period(1'b0, PER_B, 3, 6, 0, 0, -1, 8'h00);   // key0 press -> mode A
        run_period(1'b0, PER_A, 0, 0, 0, 0, 5, 8'h4F);    // ch0 duty 8->15 mid-period
        run_period(1'b0, PER_A, 0, 0, 0, 0, 3, 8'hF0);    // ch0 18 high; then {0,15}
        run_period(1'b0, 8, 0, 0, 0, 0, -1, 8'h00);       // ch1 high, ch0 never

        mon_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_pwm",  32'(bus.pwm), 32'd0);
        chk("midrst_led0", 32'(bus.led0), 32'd1);
        chk("midrst_led1", 32'(bus.led1), 32'd0);
        chk("midrst_tick", 32'(bus.period_tick), 32'd0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mode_b = 1'b0;
        c0     = 0;
        c1     = 0;
        mon_en = 1'b1;

        run_period(1'b0, PER_A, 0, 0, 0, 0, -1, 8'h00);   // post-reset period, pwm low
        run_period(1'b0, PER_A, 0, 0, 0, 0, -1, 8'h00);   // ch0 0, ch1 18

        mon_en = 1'b0;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
